// File: rtl/rrarb_grant_ctrl.sv
// Round-robin grant controller: one registered one-hot grant at a time, held until acked.
// The rotation pointer is kept as a mask of indices above the last acked grant.
module right_find_1st_one #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] onehot,
   output logic [IDW-1:0]   idx,
   output logic             found
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (vec[i] && !found) begin
            onehot[i] = 1'b1;
            idx       = IDW'(i);
            found     = 1'b1;
         end
      end
   end

endmodule

module rrarb_grant_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   input  logic             ack,
   output logic [WIDTH-1:0] gnt,
   output logic             gnt_vld,
   output logic [IDW-1:0]   gnt_id
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic [WIDTH-1:0] mask_q, mask_d;

   logic [WIDTH-1:0] masked;
   logic [WIDTH-1:0] m_onehot, r_onehot;
   logic [IDW-1:0]   m_idx, r_idx;
   logic             m_found, r_found;

   assign masked = req & mask_q;

   right_find_1st_one #(.WIDTH(WIDTH), .IDW(IDW)) u_pick_masked (
      .vec    (masked),
      .onehot (m_onehot),
      .idx    (m_idx),
      .found  (m_found)
   );

   right_find_1st_one #(.WIDTH(WIDTH), .IDW(IDW)) u_pick_req (
      .vec    (req),
      .onehot (r_onehot),
      .idx    (r_idx),
      .found  (r_found)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req != '0) state_d = GRANT;
         GRANT:   if (ack)       state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      mask_d    = mask_q;
      case (state_q)
         IDLE: begin
            if (r_found) begin
               gnt_d     = m_found ? m_onehot : r_onehot;
               gnt_id_d  = m_found ? m_idx    : r_idx;
               gnt_vld_d = 1'b1;
            end else begin
               gnt_d     = '0;
               gnt_id_d  = '0;
               gnt_vld_d = 1'b0;
            end
         end
         GRANT: begin
            if (ack) begin
               // Next search starts just above the acked index; top index wraps to all-zero.
               for (int unsigned i = 0; i < WIDTH; i++)
                  mask_d[i] = (i > 32'(gnt_id_q));
               gnt_d     = '0;
               gnt_id_d  = '0;
               gnt_vld_d = 1'b0;
            end
         end
         default: begin
            gnt_d     = '0;
            gnt_id_d  = '0;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         gnt_vld_q <= 1'b0;
         mask_q    <= '1;
      end else begin
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
         mask_q    <= mask_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rrarb_grant_ctrl.sv
// Bench for rrarb_grant_ctrl: directed scenarios on a 4-wide instance, randomized
// traffic on a 5-wide instance against a circular-priority reference model.
module tb_rrarb_grant_ctrl;

   logic       clk = 1'b0;
   logic       rst4, ack4, vld4;
   logic [3:0] req4, gnt4;
   logic [1:0] id4;
   logic       rst5, ack5, vld5;
   logic [4:0] req5, gnt5;
   logic [2:0] id5;

   int checks   = 0;
   int failures = 0;

   // Reference model for the 5-wide instance: last acked index (-1 = none since reset).
   bit m_busy;
   int m_cur;
   int m_last;
   int m_wait [5];

   always #5 clk = ~clk;

   rrarb_grant_ctrl #(.WIDTH(4), .IDW(2)) u4 (
      .clk(clk), .rst(rst4), .req(req4), .ack(ack4),
      .gnt(gnt4), .gnt_vld(vld4), .gnt_id(id4)
   );

   rrarb_grant_ctrl #(.WIDTH(5), .IDW(3)) u5 (
      .clk(clk), .rst(rst5), .req(req5), .ack(ack5),
      .gnt(gnt5), .gnt_vld(vld5), .gnt_id(id5)
   );

   // Circular search starting one past the last acked requester.
   function automatic int rr_pick(input logic [4:0] r, input int last);
      for (int k = 1; k <= 5; k++) begin
         int c;
         c = (last + k) % 5;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst5) begin
         m_busy = 1'b0;
         m_last = -1;
         for (int i = 0; i < 5; i++) m_wait[i] = 0;
      end else if (m_busy) begin
         if (ack5) begin
            m_busy = 1'b0;
            m_last = m_cur;
         end
      end else if (req5 != 5'b0) begin
         m_cur  = rr_pick(req5, m_last);
         m_busy = 1'b1;
         for (int i = 0; i < 5; i++) begin
            if (i == m_cur)  m_wait[i] = 0;
            else if (req5[i]) m_wait[i] = m_wait[i] + 1;
            else             m_wait[i] = 0;
         end
      end
      #1;
   endtask

   task automatic reset4();
      rst4 = 1'b1; req4 = '0; ack4 = 1'b0;
      tick();
      rst4 = 1'b0;
   endtask

   task automatic test_reset();
      rst4 = 1'b1; req4 = 4'b1111; ack4 = 1'b1;
      tick(); tick();
      checks++;
      if (gnt4 !== 4'b0 || vld4 !== 1'b0 || id4 !== 2'd0) begin
         failures++;
         $display("FAIL reset_state: gnt=%b vld=%b id=%0d, required 0000/0/0", gnt4, vld4, id4);
      end
      rst4 = 1'b0;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_seq [9];
      exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
      reset4();
      req4 = 4'b1111; ack4 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if (gnt4 !== exp_seq[i] || vld4 !== (exp_seq[i] != 4'b0)) begin
            failures++;
            $display("FAIL rotation[%0d]: gnt=%b vld=%b, required %b/%b", i, gnt4, vld4,
                     exp_seq[i], (exp_seq[i] != 4'b0));
         end
      end
      ack4 = 1'b0;
   endtask

   task automatic test_fallback();
      reset4();
      req4 = 4'b0101; ack4 = 1'b0;
      tick();
      checks++;
      if (gnt4 !== 4'b0001) begin
         failures++;
         $display("FAIL fallback_first: gnt=%b, required 0001", gnt4);
      end
      ack4 = 1'b1;
      tick();
      ack4 = 1'b0; req4 = 4'b0001;
      tick();
      checks++;
      if (gnt4 !== 4'b0001 || id4 !== 2'd0 || vld4 !== 1'b1) begin
         failures++;
         $display("FAIL fallback_second: gnt=%b id=%0d vld=%b, required 0001/0/1", gnt4, id4, vld4);
      end
   endtask

   task automatic test_hold();
      reset4();
      req4 = 4'b0100; ack4 = 1'b0;
      tick();
      req4 = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt4 !== 4'b0100 || vld4 !== 1'b1 || id4 !== 2'd2) begin
            failures++;
            $display("FAIL hold[%0d]: gnt=%b vld=%b id=%0d, required 0100/1/2", i, gnt4, vld4, id4);
         end
      end
      ack4 = 1'b1;
      tick();
      checks++;
      if (gnt4 !== 4'b0000 || vld4 !== 1'b0) begin
         failures++;
         $display("FAIL hold_release: gnt=%b vld=%b, required 0000/0", gnt4, vld4);
      end
      ack4 = 1'b0;
   endtask

   task automatic test_reset_mid();
      reset4();
      req4 = 4'b1111; ack4 = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (gnt4 !== 4'b0010) begin
         failures++;
         $display("FAIL midreset_pre: gnt=%b, required 0010", gnt4);
      end
      rst4 = 1'b1;
      tick();
      checks++;
      if (gnt4 !== 4'b0000 || vld4 !== 1'b0 || id4 !== 2'd0) begin
         failures++;
         $display("FAIL midreset_during: gnt=%b vld=%b id=%0d, required 0000/0/0", gnt4, vld4, id4);
      end
      rst4 = 1'b0;
      tick();
      checks++;
      if (gnt4 !== 4'b0001 || vld4 !== 1'b1) begin
         failures++;
         $display("FAIL midreset_after: gnt=%b vld=%b, required 0001/1", gnt4, vld4);
      end
      ack4 = 1'b0;
   endtask

   task automatic test_idle_ack();
      reset4();
      req4 = 4'b0000; ack4 = 1'b1;
      tick(); tick();
      checks++;
      if (gnt4 !== 4'b0000 || vld4 !== 1'b0) begin
         failures++;
         $display("FAIL idle_ack: gnt=%b vld=%b, required 0000/0", gnt4, vld4);
      end
      ack4 = 1'b0; req4 = 4'b1000;
      tick();
      checks++;
      if (gnt4 !== 4'b1000 || id4 !== 2'd3 || vld4 !== 1'b1) begin
         failures++;
         $display("FAIL idle_ack_grant: gnt=%b id=%0d vld=%b, required 1000/3/1", gnt4, id4, vld4);
      end
   endtask

   task automatic test_random();
      logic [4:0] exp_gnt;
      logic [2:0] exp_id;
      int         max_wait;
      rst5 = 1'b1; req5 = '0; ack5 = 1'b0;
      tick();
      rst5 = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         req5 = 5'($urandom);
         ack5 = ($urandom_range(0, 2) != 0);
         rst5 = ($urandom_range(0, 299) == 0);
         tick();
         exp_gnt = m_busy ? 5'(1 << m_cur) : 5'b0;
         exp_id  = m_busy ? 3'(m_cur) : 3'd0;
         checks++;
         if (gnt5 !== exp_gnt || id5 !== exp_id || vld5 !== m_busy) begin
            failures++;
            $display("FAIL random_model[%0d]: gnt=%b id=%0d vld=%b, required %b/%0d/%b",
                     n, gnt5, id5, vld5, exp_gnt, exp_id, m_busy);
         end
         checks++;
         if (!$onehot0(gnt5) || ((gnt5 != 5'b0) !== vld5)) begin
            failures++;
            $display("FAIL random_onehot[%0d]: gnt=%b vld=%b, required one-hot-or-zero tied to vld",
                     n, gnt5, vld5);
         end
         max_wait = 0;
         for (int i = 0; i < 5; i++) if (m_wait[i] > max_wait) max_wait = m_wait[i];
         checks++;
         if (max_wait > 4) begin
            failures++;
            $display("FAIL random_fairness[%0d]: wait=%0d, required <= 4", n, max_wait);
         end
      end
      rst5 = 1'b0; req5 = '0; ack5 = 1'b0;
   endtask

   initial begin
      rst4 = 1'b1; req4 = '0; ack4 = 1'b0;
      rst5 = 1'b1; req5 = '0; ack5 = 1'b0;
      m_busy = 1'b0; m_cur = 0; m_last = -1;
      for (int i = 0; i < 5; i++) m_wait[i] = 0;
      test_reset();
      test_rotation();
      test_fallback();
      test_hold();
      test_reset_mid();
      test_idle_ack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rrarb_grant_ctrl.md
RRARB_GRANT_CTRL -- requirements
Module: rrarb_grant_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of requesters (legal range 2..32).
REQ-002 SHALL have parameter IDW, default 2, giving the grant-index width; IDW SHALL equal ceil(log2(WIDTH)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req, input, WIDTH, request vector; bit i high means requester i wants service.
REQ-006 SHALL have port ack, input, 1, consumer acknowledge of the current grant.
REQ-007 SHALL have port gnt, output, WIDTH, registered one-hot grant vector.
REQ-008 SHALL have port gnt_vld, output, 1, high while gnt holds a live grant.
REQ-009 SHALL have port gnt_id, output, IDW, binary index of the set bit in gnt.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req == 0, SHALL stay in IDLE with gnt_vld = 0 and gnt = 0.
REQ-012 In IDLE with req != 0, SHALL form masked = req & mask.
REQ-013 In IDLE with req != 0, SHALL select the lowest-index set bit of masked if masked != 0, otherwise the lowest-index set bit of req.
REQ-014 SHALL perform the lowest-set-bit selection with an instance of the codebase's right_find_1st_one, WIDTH-parameterised, used once per candidate vector.
REQ-015 SHALL register the selected one-hot into gnt, its index into gnt_id, and 1 into gnt_vld, and move to GRANT on the same edge; latency is req sampled at edge N, gnt_vld high after edge N.
REQ-016 In GRANT, SHALL hold gnt, gnt_id and gnt_vld stable until ack = 1, regardless of req changes, including withdrawal of the granted request.
REQ-017 In GRANT with ack = 1, SHALL load mask with ones at all indices strictly above gnt_id and zeros at all others.
REQ-018 In GRANT with ack = 1, SHALL clear gnt, gnt_id and gnt_vld and return to IDLE on the same edge.
REQ-019 SHALL have a minimum grant spacing of 2 cycles (one IDLE bubble between grants).
REQ-020 Wrap-around: after a grant to index WIDTH-1, mask SHALL become all-zero, so the next selection falls back to unmasked req (lowest index wins).
REQ-021 SHALL ignore ack while in IDLE, with no state or mask change.
REQ-022 SHALL guarantee that gnt is always zero or one-hot, and that gnt != 0 if and only if gnt_vld = 1.
REQ-023 SHALL guarantee that gnt_id equals the index of the gnt bit when gnt_vld = 1 and equals 0 otherwise.
REQ-024 Fairness: with all WIDTH requests held continuously, each requester SHALL receive exactly one grant per WIDTH grants.
REQ-025 SHALL keep all outputs driven directly from flops (no combinational path from req or ack to outputs).

Reset
REQ-026 When rst = 1 at a clock edge, SHALL set FSM = IDLE, gnt = 0, gnt_id = 0, gnt_vld = 0, and mask = all-ones.
REQ-027 Reset SHALL override ack and req in the same cycle.
REQ-028 Reset asserted mid-grant SHALL abandon the grant without updating mask from it.
REQ-029 The first cycle after rst deasserts SHALL behave as IDLE.

Verification
REQ-030 WIDTH=4, req=4'b1111 held, ack=1 in every GRANT cycle -> grant sequence 0001, 0010, 0100, 1000, 0001; gnt_vld pattern 1,0,1,0,...
REQ-031 req=4'b0101, first grant 0001 acked, then req=4'b0001 -> next grant is 0001 (masked empty, fallback to unmasked).
REQ-032 Grant 0100 issued, req drops to 0, ack held low 5 cycles -> gnt stays 0100 and gnt_vld stays 1 for all 5 cycles; ack=1 -> both clear next edge.
REQ-033 After grants to 0001 and 0010, rst=1 for one cycle with req=4'b1111 held -> outputs 0 during reset, next grant 0001 (mask restored to all-ones).
REQ-034 ack=1 pulsed in IDLE with req=0, then req=4'b1000 -> no spurious grant; grant 1000 appears one edge after req, and gnt_id = 3.
REQ-035 Random req/ack for 10k cycles, WIDTH=5 -> REQ-022 and REQ-023 hold every cycle, and no requester held continuously waits more than WIDTH grants.
